// File: rtl/stage_mem_lsu_pkg.sv
// Shared definitions for the MEM stage: load-op encodings, FSM states, default widths.
package stage_mem_lsu_pkg;
   localparam int DATA_W_DEF  = 32;
   localparam int PC_W_DEF    = 32;
   localparam int RADDR_W_DEF = 5;

   typedef enum logic [2:0] {
      LD_NONE = 3'b000,
      LD_B    = 3'b001,
      LD_H    = 3'b010,
      LD_W    = 3'b011,
      LD_BU   = 3'b101,
      LD_HU   = 3'b110
   } ld_op_e;

   typedef enum logic [1:0] {
      MEM_EMPTY = 2'd0,
      MEM_WAIT  = 2'd1,
      MEM_READY = 2'd2,
      MEM_DRAIN = 2'd3
   } mem_state_e;
endpackage

// File: rtl/stage_mem_lsu_if.sv
// EX->MEM->WB pipeline bus plus data-SRAM response and ID forwarding tap.
interface stage_mem_lsu_if #(
   parameter int DATA_W  = stage_mem_lsu_pkg::DATA_W_DEF,
   parameter int PC_W    = stage_mem_lsu_pkg::PC_W_DEF,
   parameter int RADDR_W = stage_mem_lsu_pkg::RADDR_W_DEF
);
   logic               valid_in;
   logic               allow_in;
   logic               flush;
   logic [PC_W-1:0]    in_pc;
   logic [DATA_W-1:0]  in_alu_result;
   logic               in_rf_we;
   logic [RADDR_W-1:0] in_dest;
   logic [2:0]         in_ld_op;
   logic               mem_rvalid;
   logic [DATA_W-1:0]  mem_rdata;
   logic               valid_out;
   logic               allow_out;
   logic [PC_W-1:0]    out_pc;
   logic               out_rf_we;
   logic [RADDR_W-1:0] out_dest;
   logic [DATA_W-1:0]  out_result;
   logic               fwd_valid;
   logic               fwd_ready;

   modport master (
      output valid_in, flush, in_pc, in_alu_result, in_rf_we, in_dest, in_ld_op,
             mem_rvalid, mem_rdata, allow_out,
      input  allow_in, valid_out, out_pc, out_rf_we, out_dest, out_result,
             fwd_valid, fwd_ready
   );

   modport slave (
      input  valid_in, flush, in_pc, in_alu_result, in_rf_we, in_dest, in_ld_op,
             mem_rvalid, mem_rdata, allow_out,
      output allow_in, valid_out, out_pc, out_rf_we, out_dest, out_result,
             fwd_valid, fwd_ready
   );
endinterface

// File: rtl/stage_mem_lsu_align.sv
// Load data alignment: picks the addressed byte/half lane of the SRAM word and extends it.
module mem_load_align
   import stage_mem_lsu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
   input  logic [2:0]                  ld_op,
   input  logic [DATA_W-1:0]           rdata,
   output logic [DATA_W-1:0]           result
);
   localparam int LANES = DATA_W/8;
   localparam int OFF_W = $clog2(LANES);

   logic [LANES-1:0][7:0]    lane_b;
   logic [LANES/2-1:0][15:0] lane_h;
   logic [7:0]               b;
   logic [15:0]              h;

   assign lane_b = rdata;
   assign lane_h = rdata;
   assign b      = lane_b[addr_lo];
   // halfword ignores the low offset bit; misaligned halves are trapped upstream
   assign h      = lane_h[addr_lo[OFF_W-1:1]];

   always_comb begin
      result = rdata;
      case (ld_op_e'(ld_op))
         LD_B:    result = {{(DATA_W-8){b[7]}}, b};
         LD_H:    result = {{(DATA_W-16){h[15]}}, h};
         LD_BU:   result = {{(DATA_W-8){1'b0}}, b};
         LD_HU:   result = {{(DATA_W-16){1'b0}}, h};
         default: result = rdata;
      endcase
   end
endmodule

// File: rtl/stage_mem_lsu.sv
// MEM pipeline stage: one-entry stage register, load-response wait, flush/drain, forwarding tap.
module stage_mem_lsu
   import stage_mem_lsu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PC_W    = PC_W_DEF,
   parameter int RADDR_W = RADDR_W_DEF
) (
   input logic            clk,
   input logic            reset,
   stage_mem_lsu_if.slave bus
);
   localparam int OFF_W = $clog2(DATA_W/8);

   mem_state_e         state, state_nx;
   logic [PC_W-1:0]    pc_q;
   logic               rf_we_q;
   logic [RADDR_W-1:0] dest_q;
   logic [2:0]         ld_op_q;
   logic [OFF_W-1:0]   off_q;
   logic [DATA_W-1:0]  result_q;
   logic [DATA_W-1:0]  ld_data;
   logic               allow_in;
   logic               capture;
   logic               ld_done;

   mem_load_align #(.DATA_W(DATA_W)) u_align (
      .addr_lo (off_q),
      .ld_op   (ld_op_q),
      .rdata   (bus.mem_rdata),
      .result  (ld_data)
   );

   always_comb begin
      state_nx = state;
      allow_in = 1'b0;
      capture  = 1'b0;
      ld_done  = 1'b0;
      if (bus.flush) begin
         // a load already issued still owes its SRAM response, so it must be drained
         case (state)
            MEM_WAIT, MEM_DRAIN: state_nx = bus.mem_rvalid ? MEM_EMPTY : MEM_DRAIN;
            default:             state_nx = MEM_EMPTY;
         endcase
      end else begin
         allow_in = (state == MEM_EMPTY) || ((state == MEM_READY) && bus.allow_out);
         capture  = bus.valid_in && allow_in;
         case (state)
            MEM_EMPTY, MEM_READY: begin
               if (capture)
                  state_nx = (ld_op_e'(bus.in_ld_op) == LD_NONE) ? MEM_READY : MEM_WAIT;
               else if (state == MEM_READY && bus.allow_out)
                  state_nx = MEM_EMPTY;
            end
            MEM_WAIT: begin
               if (bus.mem_rvalid) begin
                  state_nx = MEM_READY;
                  ld_done  = 1'b1;
               end
            end
            MEM_DRAIN: if (bus.mem_rvalid) state_nx = MEM_EMPTY;
            default:   state_nx = MEM_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= MEM_EMPTY;
         pc_q     <= '0;
         rf_we_q  <= 1'b0;
         dest_q   <= '0;
         ld_op_q  <= '0;
         off_q    <= '0;
         result_q <= '0;
      end else begin
         state <= state_nx;
         if (capture) begin
            pc_q     <= bus.in_pc;
            rf_we_q  <= bus.in_rf_we;
            dest_q   <= bus.in_dest;
            ld_op_q  <= bus.in_ld_op;
            off_q    <= bus.in_alu_result[OFF_W-1:0];
            result_q <= bus.in_alu_result;
         end else if (ld_done) begin
            result_q <= ld_data;
         end
      end
   end

   assign bus.allow_in   = allow_in;
   assign bus.valid_out  = (state == MEM_READY);
   assign bus.out_pc     = pc_q;
   assign bus.out_rf_we  = rf_we_q;
   assign bus.out_dest   = dest_q;
   assign bus.out_result = result_q;
   assign bus.fwd_valid  = rf_we_q && ((state == MEM_WAIT) || (state == MEM_READY));
   assign bus.fwd_ready  = (state == MEM_READY);
endmodule

// File: tb/tb_stage_mem_lsu.sv
// Scoreboard bench for stage_mem_lsu: directed + random EX/SRAM/WB traffic vs a reference model.
module tb_stage_mem_lsu;
   import stage_mem_lsu_pkg::*;

   localparam int DW = 32;
   localparam int NDIR = 11;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   stage_mem_lsu_if #(.DATA_W(DW), .PC_W(32), .RADDR_W(5)) bus ();
   stage_mem_lsu #(.DATA_W(DW), .PC_W(32), .RADDR_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
   stage_mem_lsu_if #(.DATA_W(64), .PC_W(32), .RADDR_W(5)) bus64 ();
   stage_mem_lsu #(.DATA_W(64), .PC_W(32), .RADDR_W(5)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

   typedef struct {
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  dest;
      logic [63:0] result;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] rdata;
      int          dly;
      int          fat;
      int          hold;
      logic [4:0]  dest;
   } dir_t;

   dir_t dir [NDIR] = '{
      '{3'd0, 32'h11,   32'h0,         0, -1, 0, 5'd1},
      '{3'd0, 32'h22,   32'h0,         0, -1, 0, 5'd2},
      '{3'd0, 32'h33,   32'h0,         0, -1, 0, 5'd3},
      '{3'd1, 32'h1003, 32'h80FF_0000, 2, -1, 0, 5'd4},
      '{3'd5, 32'h1003, 32'h80FF_0000, 2, -1, 0, 5'd5},
      '{3'd2, 32'h1002, 32'h80FF_0000, 2, -1, 0, 5'd6},
      '{3'd0, 32'hCAFE, 32'h0,         0, -1, 4, 5'd7},
      '{3'd0, 32'hBEEF, 32'h0,         0, -1, 0, 5'd8},
      '{3'd3, 32'h2000, 32'h1234_5678, 3,  1, 0, 5'd9},
      '{3'd3, 32'h2004, 32'h8765_4321, 1,  1, 0, 5'd10},
      '{3'd6, 32'h1002, 32'h80FF_0000, 0, -1, 0, 5'd11}
   };
   logic [2:0] ops_r [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};

   int   errors = 0, checks = 0;
   exp_t q[$];
   exp_t me;
   bit   pend = 0, dr = 0, in_reset = 1, done32 = 0, issue = 1;
   int   idx = 0, cnt = 0, hold = 0;
   logic [31:0] h_pc, h_addr, h_rdata;
   logic [4:0]  h_dest;
   logic        h_we;
   logic [2:0]  h_op;
   int          h_dly, h_fat;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference load result from plain arithmetic on the addressed lane
   function automatic logic [63:0] model(int w, logic [2:0] op, logic [63:0] addr, logic [63:0] rdata);
      longint unsigned lanes, mask, b, h, v;
      lanes = longint'(w / 8);
      mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      b = (rdata >> ((addr % lanes) * 8)) & 64'hFF;
      h = (rdata >> (((addr % lanes) / 2) * 16)) & 64'hFFFF;
      case (op)
         3'b001:  v = (b >= 128) ? b - 256 : b;
         3'b010:  v = (h >= 32768) ? h - 65536 : h;
         3'b101:  v = b;
         3'b110:  v = h;
         default: v = rdata;
      endcase
      return v & mask;
   endfunction

   task automatic step();
      bit   cap, fl, rv;
      exp_t e;
      @(negedge clk);
      cap = bus.valid_in & bus.allow_in;
      fl  = bus.flush;
      rv  = bus.mem_rvalid;
      @(posedge clk); #1;
      if (rv && pend && !fl && !dr) begin
         e = '{h_pc, h_we, h_dest, model(DW, h_op, 64'(h_addr), 64'(h_rdata))};
         q.push_back(e);
      end
      if (fl) begin
         q.delete();
         if (pend && !rv) dr = 1;
      end
      if (rv) begin pend = 0; dr = 0; end
      if (cap) begin
         if (bus.in_ld_op == 3'b000) begin
            e = '{bus.in_pc, bus.in_rf_we, bus.in_dest, 64'(bus.in_alu_result)};
            q.push_back(e);
         end else begin
            pend = 1; cnt = 0;
            h_pc = bus.in_pc; h_we = bus.in_rf_we; h_dest = bus.in_dest;
            h_op = bus.in_ld_op; h_addr = bus.in_alu_result;
            h_dly = (idx < NDIR) ? dir[idx].dly : int'($urandom_range(0, 3));
            h_rdata = (idx < NDIR) ? dir[idx].rdata : $urandom;
            h_fat = (idx < NDIR) ? dir[idx].fat : -1;
         end
         if (idx < NDIR) begin hold = dir[idx].hold; idx++; end
      end
      bus.mem_rvalid = 1'b0;
      bus.flush = 1'b0;
      bus.mem_rdata = $urandom;
      if (pend) begin
         if (cnt == h_dly) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = h_rdata; end
         if (cnt == h_fat) bus.flush = 1'b1;
         cnt++;
      end
      if (issue && idx >= NDIR && ($urandom % 25) == 0) bus.flush = 1'b1;
      if (bus.flush || hold > 0) begin
         bus.allow_out = 1'b0;
         if (hold > 0) hold--;
      end else begin
         bus.allow_out = (idx < NDIR || !issue) ? 1'b1 : (($urandom % 10) < 7);
      end
      if (!issue) begin
         bus.valid_in = 1'b0;
      end else if (idx < NDIR) begin
         bus.valid_in = 1'b1;
         bus.in_ld_op = dir[idx].op;
         bus.in_alu_result = dir[idx].addr;
         bus.in_dest = dir[idx].dest;
         bus.in_rf_we = 1'b1;
         bus.in_pc = 32'h100 + 32'(idx) * 4;
      end else begin
         bus.valid_in = (($urandom % 4) != 0);
         bus.in_ld_op = ops_r[$urandom % 8];
         bus.in_alu_result = $urandom;
         bus.in_dest = 5'($urandom);
         bus.in_rf_we = 1'($urandom);
         bus.in_pc = $urandom;
      end
   endtask

   task automatic run64();
      logic [63:0] rd, a, e;
      logic [2:0]  op;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin
            op = 3'b110; a = 64'h6; rd = 64'hBEEF_0000_0000_0000;
            e = 64'h0000_0000_0000_BEEF;
         end else begin
            op = ops_r[3 + ($urandom % 5)];
            a = {$urandom, $urandom}; rd = {$urandom, $urandom};
            e = model(64, op, a, rd);
         end
         @(posedge clk); #1;
         bus64.valid_in = 1'b1; bus64.in_ld_op = op; bus64.in_alu_result = a;
         bus64.in_dest = 5'(i); bus64.in_rf_we = 1'b1; bus64.allow_out = 1'b1;
         @(posedge clk); #1;
         bus64.valid_in = 1'b0;
         chk("w64_wait_allow_in", 64'(bus64.allow_in), 64'd0);
         bus64.mem_rvalid = 1'b1; bus64.mem_rdata = rd;
         @(posedge clk); #1;
         bus64.mem_rvalid = 1'b0;
         chk("w64_valid_out", 64'(bus64.valid_out), 64'd1);
         chk("w64_result", bus64.out_result, e);
      end
   endtask

   always @(negedge clk) begin
      if (!in_reset && !done32) begin
         if (bus.flush) chk("flush_allow_in", 64'(bus.allow_in), 64'd0);
         if (pend) begin
            chk("wait_allow_in", 64'(bus.allow_in), 64'd0);
            chk("wait_valid_out", 64'(bus.valid_out), 64'd0);
            chk("wait_fwd_ready", 64'(bus.fwd_ready), 64'd0);
         end else if (q.size() == 0) begin
            chk("idle_valid_out", 64'(bus.valid_out), 64'd0);
            chk("idle_allow_in", 64'(bus.allow_in), 64'(!bus.flush));
         end
         if (bus.valid_out && !bus.allow_out && q.size() > 0) begin
            chk("hold_allow_in", 64'(bus.allow_in), 64'd0);
            chk("hold_result", 64'(bus.out_result), q[0].result);
            chk("hold_pc", 64'(bus.out_pc), 64'(q[0].pc));
         end
         if (bus.valid_out && bus.allow_out) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_wb: pc=%0h result=%0h with no expected entry", bus.out_pc, bus.out_result);
            end else begin
               me = q.pop_front();
               chk("wb_pc", 64'(bus.out_pc), 64'(me.pc));
               chk("wb_dest", 64'(bus.out_dest), 64'(me.dest));
               chk("wb_rf_we", 64'(bus.out_rf_we), 64'(me.rf_we));
               chk("wb_result", 64'(bus.out_result), me.result);
               chk("wb_fwd_valid", 64'(bus.fwd_valid), 64'(me.rf_we));
               chk("wb_fwd_ready", 64'(bus.fwd_ready), 64'd1);
               if (!bus.flush) chk("wb_allow_in", 64'(bus.allow_in), 64'd1);
            end
         end
      end
   end

   initial begin
      bus.valid_in = 0; bus.flush = 0; bus.in_pc = 0; bus.in_alu_result = 0; bus.in_rf_we = 0;
      bus.in_dest = 0; bus.in_ld_op = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.allow_out = 1;
      bus64.valid_in = 0; bus64.flush = 0; bus64.in_pc = 0; bus64.in_alu_result = 0; bus64.in_rf_we = 0;
      bus64.in_dest = 0; bus64.in_ld_op = 0; bus64.mem_rvalid = 0; bus64.mem_rdata = 0; bus64.allow_out = 1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
      chk("rst_allow_in", 64'(bus.allow_in), 64'd1);
      chk("rst_out_result", 64'(bus.out_result), 64'd0);
      chk("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
      chk("rst_fwd_ready", 64'(bus.fwd_ready), 64'd0);
      chk("rst64_result", bus64.out_result, 64'd0);
      reset = 1'b0;
      in_reset = 0;
      repeat (2000) step();
      issue = 0;
      for (int i = 0; i < 40 && (pend || q.size() > 0); i++) step();
      chk("drain_timeout", 64'(pend || q.size() != 0), 64'd0);
      chk("directed_all_issued", 64'(idx), 64'(NDIR));
      done32 = 1;
      run64();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
